ram_dma_engine: RTL

Command-driven bus master that sits directly upstream of synch_ram and drives its chipsel/writeEn/readEn/addrIn/busIn pins, consuming busOut.
Performs two bulk operations on the 64 KiB byte RAM:
- block copy from a source range to a destination range;
- block fill of a range with a constant byte.

Replaces hand-sequenced RAM access in benches and in the loader path. One command in flight; completion is signalled by a single-cycle done pulse.

---
 rtl/ram_dma_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_dma_engine.sv
// Command-driven bus master for synch_ram: block copy (read, capture, write per byte)
// and block fill (one write per byte), one command in flight, single-cycle done pulse.
module ram_dma_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fillData,
    output logic              busy,
    output logic              done,
    output logic              ramCs,
    output logic              ramWen,
    output logic              ramRen,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

    state_e            state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  idx_inc;
    logic [DATA_W-1:0] fill_q;

    assign idx_inc = idx_q + LEN_W'(1);

    // Outputs are registered: each transition loads the strobes/address of the state entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            fill_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ramCs    <= 1'b0;
            ramWen   <= 1'b0;
            ramRen   <= 1'b0;
            ramAddr  <= '0;
            ramWdata <= '0;
        end else begin
            done   <= 1'b0;
            ramCs  <= 1'b0;
            ramWen <= 1'b0;
            ramRen <= 1'b0;
            case (state_q)
                StIdle: begin
                    busy <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= srcAddr;
                        dst_q  <= dstAddr;
                        len_q  <= length;
                        fill_q <= fillData;
                        idx_q  <= '0;
                        busy   <= 1'b1;
                        if (length == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (!mode) begin
                            state_q <= StRd;
                            ramCs   <= 1'b1;
                            ramRen  <= 1'b1;
                            ramAddr <= srcAddr;
                        end else begin
                            state_q  <= StWr;
                            ramCs    <= 1'b1;
                            ramWen   <= 1'b1;
                            ramAddr  <= dstAddr;
                            ramWdata <= fillData;
                        end
                    end
                end
                StRd: begin
                    state_q <= StCap;
                end
                StCap: begin
                    // Read data lands at the end of this cycle; it becomes the write data.
                    state_q  <= StWr;
                    ramCs    <= 1'b1;
                    ramWen   <= 1'b1;
                    ramAddr  <= dst_q + ADDR_W'(idx_q);
                    ramWdata <= ramRdata;
                end
                StWr: begin
                    idx_q <= idx_inc;
                    if (idx_inc == len_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else if (mode_q) begin
                        state_q  <= StWr;
                        ramCs    <= 1'b1;
                        ramWen   <= 1'b1;
                        ramAddr  <= dst_q + ADDR_W'(idx_inc);
                        ramWdata <= fill_q;
                    end else begin
                        state_q <= StRd;
                        ramCs   <= 1'b1;
                        ramRen  <= 1'b1;
                        ramAddr <= src_q + ADDR_W'(idx_inc);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
